// File: rtl/awg_load_ctrl.sv
// Write-side sequencer: packs a 16-bit AXI-Stream into 8-lane rows of the AWG waveform memory.
// Define AWG_LOAD_TIMEOUT_EN to build a stall watchdog that aborts a load starved of samples.
module awg_load_ctrl #(
    parameter int RAM_DEPTH      = 15,
    parameter int LANES          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_aresetn,
    input  logic                     cmd_start,
    input  logic                     cmd_ch,
    input  logic [RAM_DEPTH:0]       cmd_rows,
    input  logic                     cmd_abort,
    input  logic [15:0]              s00_axis_tdata,
    input  logic                     s00_axis_tvalid,
    input  logic                     s00_axis_tlast,
    output logic                     s00_axis_tready,
    output logic [1:0]               we,
    output logic [RAM_DEPTH-1:0]     row,
    output logic [$clog2(LANES)-1:0] col,
    output logic [15:0]              gpio_data_out,
    output logic [31:0]              max_points,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int                   COL_W    = $clog2(LANES);
    localparam logic [RAM_DEPTH:0]   ROWS_ONE = {{RAM_DEPTH{1'b0}}, 1'b1};
    localparam logic [RAM_DEPTH:0]   ROWS_MAX = {1'b1, {RAM_DEPTH{1'b0}}};
    localparam logic [COL_W-1:0]     COL_LAST = COL_W'(LANES - 1);
    localparam logic [COL_W-1:0]     COL_ONE  = COL_W'(1);
    localparam logic [RAM_DEPTH-1:0] ROW_ONE  = RAM_DEPTH'(1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic                 ch_q, ch_d;
    logic [RAM_DEPTH:0]   rows_q, rows_d;
    logic [RAM_DEPTH-1:0] row_cnt_q, row_cnt_d;
    logic [COL_W-1:0]     col_cnt_q, col_cnt_d;
    logic [1:0]           we_q, we_d;
    logic [RAM_DEPTH-1:0] row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [15:0]          data_q, data_d;
    logic [31:0]          max_q, max_d;
    logic                 err_q, err_d;

    logic [RAM_DEPTH:0]   rows_m1;
    logic                 start_ok;
    logic                 last_beat;
    logic                 stall_hit;

    assign rows_m1   = rows_q - ROWS_ONE;
    assign start_ok  = (cmd_rows != '0) && (cmd_rows <= ROWS_MAX);
    assign last_beat = ({1'b0, row_cnt_q} == rows_m1) && (col_cnt_q == COL_LAST);

`ifdef AWG_LOAD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;

    // Counts consecutive sample-less LOAD cycles; fires on the TIMEOUT_CYCLES-th one.
    assign stall_hit = (state_q == LOAD) && !s00_axis_tvalid &&
                       (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stall_d = '0;
        if (state_q == LOAD && !s00_axis_tvalid)
            stall_d = stall_q + STALL_W'(1);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) stall_q <= '0;
        else                   stall_q <= stall_d;
    end
`else
    // No watchdog: LOAD waits for samples indefinitely.
    assign stall_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rows_d    = rows_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        we_d      = we_q;
        row_d     = row_q;
        col_d     = col_q;
        data_d    = data_q;
        max_d     = max_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    if (start_ok) begin
                        ch_d      = cmd_ch;
                        rows_d    = cmd_rows;
                        row_cnt_d = '0;
                        col_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Abort wins over a same-cycle beat; that beat is dropped.
                if (cmd_abort || stall_hit) begin
                    we_d    = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (s00_axis_tvalid) begin
                    data_d = s00_axis_tdata;
                    row_d  = row_cnt_q;
                    col_d  = col_cnt_q;
                    we_d   = ch_q ? 2'd2 : 2'd1;
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + ROW_ONE;
                    end else begin
                        col_cnt_d = col_cnt_q + COL_ONE;
                    end
                    // tlast only cross-checks the row count; the count decides the end.
                    if (last_beat) begin
                        state_d = FLUSH;
                        if (!s00_axis_tlast) err_d = 1'b1;
                    end else if (s00_axis_tlast) begin
                        err_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (cmd_abort) begin
                    we_d    = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    we_d    = '0;
                    max_d   = {{(31-RAM_DEPTH){1'b0}}, rows_m1};
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q   <= IDLE;
            ch_q      <= 1'b0;
            rows_q    <= '0;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            we_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            max_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rows_q    <= rows_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            we_q      <= we_d;
            row_q     <= row_d;
            col_q     <= col_d;
            data_q    <= data_d;
            max_q     <= max_d;
            err_q     <= err_d;
        end
    end

    assign s00_axis_tready = (state_q == LOAD);
    assign busy            = (state_q == LOAD) || (state_q == FLUSH);
    assign done            = (state_q == DONE);
    assign we              = we_q;
    assign row             = row_q;
    assign col             = col_q;
    assign gpio_data_out   = data_q;
    assign max_points      = max_q;
    assign err             = err_q;

endmodule

// File: tb/tb_awg_load_ctrl.sv
// Bench for awg_load_ctrl: drives loads, models the waveform memory, checks placement and handshakes.
module tb_awg_load_ctrl;

    localparam int RD = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_ch = 1'b0;
    logic [RD:0]   cmd_rows = '0;
    logic          cmd_abort = 1'b0;
    logic [15:0]   tdata = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          tready;
    logic [1:0]    we;
    logic [RD-1:0] row;
    logic [2:0]    col;
    logic [15:0]   gpio_data_out;
    logic [31:0]   max_points;
    logic          busy;
    logic          done;
    logic          err;

    awg_load_ctrl #(.RAM_DEPTH(RD), .LANES(8), .TIMEOUT_CYCLES(16)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .cmd_start       (cmd_start),
        .cmd_ch          (cmd_ch),
        .cmd_rows        (cmd_rows),
        .cmd_abort       (cmd_abort),
        .s00_axis_tdata  (tdata),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tlast  (tlast),
        .s00_axis_tready (tready),
        .we              (we),
        .row             (row),
        .col             (col),
        .gpio_data_out   (gpio_data_out),
        .max_points      (max_points),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          last_max = 0;
    logic [15:0] mem [int];

    function automatic int mkey(input int chan_code, input int r, input int c);
        return (chan_code << 20) | (r << 3) | c;
    endfunction

    // Memory model: whatever the write port shows when an edge arrives gets stored.
    task automatic tick();
        if (we != 2'd0) mem[mkey(int'(we), int'(row), int'(col))] = gpio_data_out;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input bit ch, input int rows);
        cmd_start = 1'b1;
        cmd_ch    = ch;
        cmd_rows  = (RD+1)'(rows);
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic do_load(input bit ch, input int rows, input int gmin, input int gmax,
                           input int early_last, input bit directed, input bit poke);
        logic [15:0] smp [$];
        int          n;
        int          g;
        int          key;
        bit          exp_err;
        n = rows * 8;
        exp_err = (early_last >= 0);
        mem.delete();
        for (int k = 0; k < n; k++) smp.push_back(directed ? 16'(k + 1) : 16'($urandom));
        start(ch, rows);
        chk("start_tready", 32'(tready), 1);
        chk("start_we", 32'(we), 0);
        for (int k = 0; k < n; k++) begin
            tvalid = 1'b1;
            tdata  = smp[k];
            tlast  = (early_last >= 0) ? (k == early_last) : (k == n - 1);
            tick();
            tvalid = 1'b0;
            tlast  = 1'b0;
            if (k < n - 1) begin
                chk("hold_we", 32'(we), int'(ch) + 1);
                g = $urandom_range(gmax, gmin);
                for (int j = 0; j < g; j++) begin
                    if (poke && j == 0) begin
                        cmd_start = 1'b1;
                        cmd_ch    = ~ch;
                        cmd_rows  = (RD+1)'(1);
                    end
                    tick();
                    cmd_start = 1'b0;
                    chk("gap_we", 32'(we), int'(ch) + 1);
                end
            end
        end
        chk("flush_tready", 32'(tready), 0);
        chk("flush_we", 32'(we), int'(ch) + 1);
        chk("flush_done", 32'(done), 0);
        tick();
        chk("done_pulse", 32'(done), 1);
        chk("done_we", 32'(we), 0);
        chk("max_points", max_points, rows - 1);
        chk("done_err", 32'(err), 32'(exp_err));
        tick();
        chk("done_clear", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("mem_count", mem.num(), n);
        for (int k = 0; k < n; k++) begin
            key = mkey(int'(ch) + 1, k / 8, k % 8);
            chk("mem_data", mem.exists(key) ? 32'(mem[key]) : 32'hDEAD0000, 32'(smp[k]));
        end
        last_max = rows - 1;
    endtask

    task automatic bad_start(input int rows);
        start(1'b0, rows);
        chk("bad_err", 32'(err), 1);
        chk("bad_tready", 32'(tready), 0);
        chk("bad_busy", 32'(busy), 0);
        repeat (3) begin
            tick();
            chk("bad_we", 32'(we), 0);
            chk("bad_tready_hold", 32'(tready), 0);
        end
    endtask

    initial begin
        int idle;
        // Reset state
        repeat (2) tick();
        chk("rst_we", 32'(we), 0);
        chk("rst_row", 32'(row), 0);
        chk("rst_col", 32'(col), 0);
        chk("rst_data", 32'(gpio_data_out), 0);
        chk("rst_max", max_points, 0);
        chk("rst_tready", 32'(tready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick();

        // Directed: ch0, two rows of 1..16, continuous stream
        do_load(1'b0, 2, 0, 0, -1, 1'b1, 1'b0);
        bad_start(0);
        // ch1, one row, 3-cycle gaps, ignored cmd_start while busy
        do_load(1'b1, 1, 3, 3, -1, 1'b0, 1'b1);
        bad_start((1 << RD) + 1);

        // Largest legal row count is accepted, then abandoned
        start(1'b0, 1 << RD);
        chk("max_rows_busy", 32'(busy), 1);
        chk("max_rows_err", 32'(err), 0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("max_rows_abort_err", 32'(err), 1);
        chk("max_rows_abort_max", max_points, last_max);

        // tlast on beat 3 of a one-row load
        do_load(1'b0, 1, 0, 1, 2, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++)
            do_load(1'($urandom_range(1, 0)), $urandom_range(3, 1), 0, 2, -1, 1'b0, 1'b0);

        // Abort after 5 beats with a sixth beat presented alongside
        mem.delete();
        start(1'b0, 2);
        for (int k = 0; k < 5; k++) begin
            tvalid = 1'b1;
            tdata  = 16'($urandom);
            tick();
        end
        tdata = 16'hBEEF;
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        tvalid = 1'b0;
        chk("abort_we", 32'(we), 0);
        chk("abort_err", 32'(err), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_max", max_points, last_max);
        tick();
        chk("abort_no_done", 32'(done), 0);
        chk("abort_count", mem.num(), 5);
        chk("abort_lane5", mem.exists(mkey(1, 0, 5)), 0);

        // Stall after 2 beats
        start(1'b1, 2);
        for (int k = 0; k < 2; k++) begin
            tvalid = 1'b1;
            tdata  = 16'($urandom);
            tick();
        end
        tvalid = 1'b0;
`ifdef AWG_LOAD_TIMEOUT_EN
        idle = 0;
        while (busy && idle < 40) begin
            tick();
            idle++;
        end
        chk("timeout_cycles", idle, 16);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_we", 32'(we), 0);
        chk("timeout_tready", 32'(tready), 0);
`else
        idle = 0;
        repeat (100) begin
            tick();
            idle++;
        end
        chk("stall_busy", 32'(busy), 1);
        chk("stall_tready", 32'(tready), 1);
        chk("stall_we", 32'(we), 2);
        chk("stall_err", 32'(err), 0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("stall_abort_busy", 32'(busy), 0);
        chk("stall_abort_err", 32'(err), 1);
`endif

        // Reset mid-load drops we without waiting for a clock
        start(1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            tvalid = 1'b1;
            tdata  = 16'($urandom);
            tick();
        end
        tvalid = 1'b0;
        chk("pre_reset_we", 32'(we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_we", 32'(we), 0);
        chk("async_reset_busy", 32'(busy), 0);
        chk("async_reset_max", max_points, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/awg_load_ctrl.md
# awg_load_ctrl

Write-side sequencer for the dual-channel AWG waveform memory. It accepts a host load command and a 16-bit AXI-Stream of samples, and packs the samples eight lanes per 128-bit row into the selected channel memory. It drives the memory's `we`/`row`/`col`/`gpio_data_in` write port, then releases the memory to playback and publishes the new `MAX_POINTS`.

## Interface
- `RAM_DEPTH`, 15: row address width; max load is 2^RAM_DEPTH rows.
- `LANES`, 8: 16-bit lanes per row; `col` width is clog2(LANES).
- `TIMEOUT_CYCLES`, 1024: stall limit, used only with the timeout macro.
- `s00_axis_aclk` in 1: the block's single clock.
- `s00_axis_aresetn` in 1: asynchronous, active-low reset.
- `cmd_start` in 1: one-cycle load request; sampled only in IDLE.
- `cmd_ch` in 1: target channel; 0 → we=1, 1 → we=2.
- `cmd_rows` in RAM_DEPTH+1: number of rows to load; legal range is 1..2^RAM_DEPTH.
- `cmd_abort` in 1: abandons the load in progress.
- `s00_axis_tdata` in 16: sample.
- `s00_axis_tvalid` in 1: sample valid.
- `s00_axis_tlast` in 1: end-of-waveform marker; checked, never trusted.
- `s00_axis_tready` out 1: sample accept.
- `we` out 2: memory write enable; 0 means playback.
- `row` out RAM_DEPTH: write row.
- `col` out 3: write lane.
- `gpio_data_out` out 16: write data.
- `max_points` out 32: length register for the playback read counter.
- `busy` out 1: high in LOAD and FLUSH.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky error flag; cleared by the next accepted `cmd_start`.

## Operation
- States are IDLE, LOAD, FLUSH and DONE.
- IDLE:
  - `cmd_start` with 1 ≤ `cmd_rows` ≤ 2^RAM_DEPTH latches `ch` and `rows`, clears the row/col counters and `err`, then goes to LOAD.
  - `cmd_start` with an illegal `cmd_rows` (0 or too large) sets `err` and stays in IDLE.
- LOAD:
  - `s00_axis_tready`=1.
  - Each beat (tvalid&tready) registers `gpio_data_out`=tdata, `row`=row_cnt, `col`=col_cnt, and sets `we` to the channel code.
  - `col_cnt` increments per beat and wraps 7→0; `row_cnt` increments on each wrap.
  - The first sample of a row goes to lane 0, i.e. the lowest bits of the row.
- Final beat (row_cnt=rows-1 and col_cnt=7):
  - The beat is written and the FSM goes to FLUSH.
  - If tlast=0 on this beat, set `err`.
  - Any earlier beat with tlast=1 sets `err`; the load still continues by count.
- FLUSH: one cycle with `tready`=0; `we` is still asserted so the last write completes. Then go to DONE.
- DONE:
  - `we`=0 and `done`=1 for one cycle.
  - `max_points` ← rows-1, zero-extended to 32 bits. This is inclusive, so the read counter wraps after row rows-1.
  - Then return to IDLE.
- `we` stays 0 from LOAD entry until the first accepted beat. After that it holds the channel code until DONE.
  - Cycles with no new beat re-write the same lane with the same data. This is idempotent and required, so playback is never re-enabled mid-load.
- `cmd_abort` in LOAD or FLUSH:
  - Takes priority over a same-cycle beat; the beat is not accepted.
  - Next cycle: `we`=0, `err`=1, no `done`, `max_points` unchanged, state IDLE.
- `cmd_start` while busy is ignored.

## Timing
- Reset values: `we`=0, `row`=0, `col`=0, `gpio_data_out`=0, `max_points`=0, `s00_axis_tready`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Reset asserted mid-load drops `we` to 0 immediately (asynchronously); the partially loaded memory is left as-is.
- Start to ready: `cmd_start` at edge N → `tready`=1 from cycle N+1.
- Beat to write: beat accepted at edge N → write-port outputs valid in cycle N+1 → memory write at edge N+2.
- Completion: final beat at edge N → FLUSH in N+1, DONE (`done`=1, `we`=0, `max_points` updated) in N+2, IDLE in N+3.
- `s00_axis_tready` is decoded directly from the state register, with no combinational path from `tvalid`.
- Throughput is one sample per cycle when tvalid is continuous.

## Configuration
- Macro `AWG_LOAD_TIMEOUT_EN`, defined: a stall counter runs in LOAD.
  - It clears on every accepted beat and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`, the block behaves exactly as `cmd_abort`: `we`=0, `err`=1, IDLE.
- Not defined: no counter is built, and LOAD waits indefinitely for samples.

## Test plan
- Start, ch=0, rows=2; stream 16 samples 0x0001..0x0010 with tlast on the 16th. Required:
  - `we`=1 during the load.
  - Row 0 lanes 0..7 = 1..8; row 1 lanes 0..7 = 9..16.
  - `done` pulses 2 cycles after the last beat; `max_points`=1; `err`=0.
- Start, ch=1, rows=1; insert 3-cycle tvalid gaps between beats. Required:
  - `we`=2 held continuously from the first beat to DONE.
  - Row 0 matches the stream; stalled cycles rewrite the same lane only.
- rows=0, and separately rows=2^RAM_DEPTH+1. Required: `err`=1, state stays IDLE, `we` never leaves 0, `tready`=0.
- rows=1 with tlast asserted on beat 3. Required: all 8 beats accepted, `err`=1, `done` still pulses, `max_points`=0.
- Abort after 5 beats, with a beat presented in the same cycle. Required: that beat is not accepted, `we`=0 next cycle, `err`=1, no `done`, `max_points` unchanged.
- With `AWG_LOAD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, hold tvalid low after 2 beats. Required: abort after 16 idle cycles. Without the macro: still in LOAD after 100 cycles.
